mac_dot_sequencer: RTL and testbench

- Sequences one 14x14 signed saturating multiply-accumulate unit (3-cycle valid_in to valid_out, synchronous active-high clear) through a dot-product job.
- Fetches operand pairs from two synchronous-read operand memories and clears the MAC before each job.
- Counts MAC results and returns the final accumulator over a valid/ready result handshake.
- Sits between the job-issuing host and the MAC/memory pair.

---
 rtl/mac_seq_pkg.sv | 14 +
 rtl/mac_dot_sequencer_if.sv | 54 +++++
 rtl/mac_seq_addr_gen.sv | 45 ++++
 rtl/mac_dot_sequencer.sv | 118 +++++++++++
 tb/tb_mac_dot_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_pkg.sv
// Shared widths, FSM state type and small helpers for the MAC dot-product sequencer.
package mac_seq_pkg;

  localparam int DATA_W    = 14;
  localparam int ACC_W     = 28;
  localparam int JOB_CYC_W = 16;

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, DRAIN, RESULT} state_t;

  function automatic logic [JOB_CYC_W-1:0] satInc(input logic [JOB_CYC_W-1:0] v);
    return (v == '1) ? v : v + JOB_CYC_W'(1);
  endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Host, operand-memory and MAC signal bundle for the dot-product sequencer.
// The job_cycles member exists only when MAC_SEQ_JOB_CYCLES_EN is defined.
interface mac_dot_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) ();
  import mac_seq_pkg::*;

  logic                     start;
  logic [ADDR_W-1:0]        base_addr_a;
  logic [ADDR_W-1:0]        base_addr_b;
  logic [LEN_W-1:0]         len;
  logic                     busy;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_addr_a;
  logic [ADDR_W-1:0]        mem_addr_b;
  logic signed [DATA_W-1:0] mem_rdata_a;
  logic signed [DATA_W-1:0] mem_rdata_b;
  logic                     mac_reset;
  logic                     mac_valid_in;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  mac_f;
  logic                     mac_valid_out;
  logic                     res_valid;
  logic signed [ACC_W-1:0]  res_data;
  logic                     res_ready;
`ifdef MAC_SEQ_JOB_CYCLES_EN
  logic [JOB_CYC_W-1:0]     job_cycles;
`endif

  modport master (
    input  start, base_addr_a, base_addr_b, len,
    input  mem_rdata_a, mem_rdata_b, mac_f, mac_valid_out, res_ready,
    output busy, mem_rd_en, mem_addr_a, mem_addr_b,
    output mac_reset, mac_valid_in, mac_a, mac_b,
`ifdef MAC_SEQ_JOB_CYCLES_EN
    output job_cycles,
`endif
    output res_valid, res_data
  );

  modport slave (
    output start, base_addr_a, base_addr_b, len,
    output mem_rdata_a, mem_rdata_b, mac_f, mac_valid_out, res_ready,
    input  busy, mem_rd_en, mem_addr_a, mem_addr_b,
    input  mac_reset, mac_valid_in, mac_a, mac_b,
`ifdef MAC_SEQ_JOB_CYCLES_EN
    input  job_cycles,
`endif
    input  res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// Operand address generator: loads both base addresses and the element count,
// then steps the addresses (wrapping) once per issued read.
module mac_seq_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base_a,
  input  logic [ADDR_W-1:0] i_base_b,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic              o_rd_en,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [LEN_W-1:0]  r_remaining;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr_a    <= i_base_a;
      r_addr_b    <= i_base_b;
      r_remaining <= i_len;
    end else if (i_advance) begin
      r_addr_a    <= r_addr_a + ADDR_W'(1);
      r_addr_b    <= r_addr_b + ADDR_W'(1);
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign o_addr_a = r_addr_a;
  assign o_addr_b = r_addr_b;
  assign o_rd_en  = i_advance;
  assign o_last   = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/mac_dot_sequencer.sv
// Drives one saturating MAC through a dot-product job and returns the accumulator.
// Optional cycle counter output enabled by defining MAC_SEQ_JOB_CYCLES_EN.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  mac_dot_sequencer_if.master   bus
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_vout_cnt;
  logic signed [ACC_W-1:0] r_res_data;
  logic                    r_mac_valid_in;
  logic                    w_accept;
  logic                    w_final_pulse;
  logic                    w_issue;
  logic                    w_last;

  mac_seq_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_base_a  (bus.base_addr_a),
    .i_base_b  (bus.base_addr_b),
    .i_len     (bus.len),
    .i_advance (w_issue),
    .o_addr_a  (bus.mem_addr_a),
    .o_addr_b  (bus.mem_addr_b),
    .o_rd_en   (bus.mem_rd_en),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // The final MAC result is the pulse that brings the counted total to len.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_final_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = (bus.len == '0) ? RESULT : CLR;
        end
      end
      CLR:   w_next_state = ISSUE;
      ISSUE: if (w_last) w_next_state = DRAIN;
      DRAIN: begin
        if (bus.mac_valid_out && (r_vout_cnt == r_len - LEN_W'(1))) begin
          w_final_pulse = 1'b1;
          w_next_state  = RESULT;
        end
      end
      RESULT: if (bus.res_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len          <= '0;
      r_vout_cnt     <= '0;
      r_res_data     <= '0;
      r_mac_valid_in <= 1'b0;
    end else begin
      r_mac_valid_in <= w_issue;
      if (w_accept) begin
        r_len      <= bus.len;
        r_vout_cnt <= '0;
        if (bus.len == '0) r_res_data <= '0;
      end else if ((r_state == ISSUE || r_state == DRAIN) && bus.mac_valid_out) begin
        r_vout_cnt <= r_vout_cnt + LEN_W'(1);
      end
      if (w_final_pulse) r_res_data <= bus.mac_f;
    end
  end

  assign w_issue          = (r_state == ISSUE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.mac_reset    = reset | (r_state == CLR);
  assign bus.mac_valid_in = r_mac_valid_in;
  assign bus.mac_a        = bus.mem_rdata_a;
  assign bus.mac_b        = bus.mem_rdata_b;
  assign bus.res_valid    = (r_state == RESULT);
  assign bus.res_data     = r_res_data;

`ifdef MAC_SEQ_JOB_CYCLES_EN
  logic [JOB_CYC_W-1:0] r_cyc_cnt;
  logic [JOB_CYC_W-1:0] r_job_cycles;

  // Count from the accepting edge; the captured value includes the first RESULT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt    <= '0;
      r_job_cycles <= '0;
    end else begin
      if (w_accept) r_cyc_cnt <= JOB_CYC_W'(1);
      else if (r_state == CLR || r_state == ISSUE || r_state == DRAIN)
        r_cyc_cnt <= satInc(r_cyc_cnt);
      if (w_accept && bus.len == '0) r_job_cycles <= JOB_CYC_W'(1);
      else if (w_final_pulse)        r_job_cycles <= satInc(r_cyc_cnt);
    end
  end

  assign bus.job_cycles = r_job_cycles;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench: behavioural operand memories and MAC around the sequencer,
// a vector table, hand-written corner sequences and randomized jobs vs. a reference.
module tb_mac_dot_sequencer;
  import mac_seq_pkg::*;

  localparam longint ACC_MAX = 134217727;
  localparam longint ACC_MIN = -134217728;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mac_dot_sequencer_if #(.ADDR_W(8), .LEN_W(9)) bus ();

  mac_dot_sequencer #(.ADDR_W(8), .LEN_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [13:0] memA [256];
  logic signed [13:0] memB [256];

  int passCount  = 0;
  int checkCount = 0;

  logic [7:0] qA [$];
  logic [7:0] qB [$];
  int vinCount = 0;
  int mrCount  = 0;

  typedef struct {
    logic [7:0] baseA;
    logic [7:0] baseB;
    int         len;
    int         a [4];
    int         b [4];
    longint     expData;
    int         expLat;
  } vec_t;

  vec_t vecs [7];

  function automatic longint sat(input longint v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  // Reference: saturating sum of products straight from the memory arrays.
  function automatic longint refDot(input logic [7:0] ba, input logic [7:0] bb, input int l);
    longint acc = 0;
    for (int i = 0; i < l; i++) begin
      logic [7:0] ia;
      logic [7:0] ib;
      ia  = ba + 8'(i);
      ib  = bb + 8'(i);
      acc = sat(acc + longint'(memA[ia]) * longint'(memB[ib]));
    end
    return acc;
  endfunction

  // Synchronous-read operand memories.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata_a <= memA[bus.mem_addr_a];
      bus.mem_rdata_b <= memB[bus.mem_addr_b];
    end
  end

  // Behavioural 3-cycle saturating MAC with synchronous clear.
  logic   mP1 = 1'b0;
  logic   mP2 = 1'b0;
  longint mProd1 = 0;
  longint mProd2 = 0;
  always @(posedge clk) begin
    if (bus.mac_reset) begin
      mP1               <= 1'b0;
      mP2               <= 1'b0;
      bus.mac_valid_out <= 1'b0;
      bus.mac_f         <= '0;
    end else begin
      mP1               <= bus.mac_valid_in;
      mProd1            <= longint'(bus.mac_a) * longint'(bus.mac_b);
      mP2               <= mP1;
      mProd2            <= mProd1;
      bus.mac_valid_out <= mP2;
      if (mP2) bus.mac_f <= 28'(sat(longint'(bus.mac_f) + mProd2));
    end
  end

  // Observes the memory/MAC side of each job.
  always @(negedge clk) begin
    if (bus.mem_rd_en) begin
      qA.push_back(bus.mem_addr_a);
      qB.push_back(bus.mem_addr_b);
    end
    if (bus.mac_valid_in) vinCount++;
    if (bus.mac_reset && !reset) mrCount++;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Starts a job at a falling edge and returns cycles until res_valid is seen.
  task automatic applyStimulus(input logic [7:0] ba, input logic [7:0] bb, input int l,
                               output int lat);
    @(negedge clk);
    qA.delete();
    qB.delete();
    vinCount = 0;
    mrCount  = 0;
    bus.start       = 1'b1;
    bus.base_addr_a = ba;
    bus.base_addr_b = bb;
    bus.len         = 9'(l);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic acceptResult(input string name, input int holdCycles, output longint data);
    longint first;
    first = longint'(bus.res_data);
    for (int h = 0; h < holdCycles; h++) @(negedge clk);
    data = longint'(bus.res_data);
    if (holdCycles > 0) checkOutput({name, "_hold_stable"}, data, first);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput({name, "_idle_after_accept"}, longint'(bus.busy), 0);
  endtask

  task automatic checkJob(input string name, input logic [7:0] ba, input logic [7:0] bb,
                          input int l, input longint expData, input int expLat,
                          input longint data, input int lat);
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_res_data"}, data, expData);
    checkOutput({name, "_valid_in_cycles"}, vinCount, l);
    checkOutput({name, "_mac_reset_cycles"}, mrCount, (l > 0) ? 1 : 0);
    checkOutput({name, "_reads"}, qA.size(), l);
    for (int i = 0; i < l && i < qA.size(); i++) begin
      checkOutput($sformatf("%s_addr_a[%0d]", name, i), qA[i], 8'(ba + 8'(i)));
      checkOutput($sformatf("%s_addr_b[%0d]", name, i), qB[i], 8'(bb + 8'(i)));
    end
`ifdef MAC_SEQ_JOB_CYCLES_EN
    checkOutput({name, "_job_cycles"}, bus.job_cycles, expLat);
`endif
  endtask

  initial begin
    int     lat;
    longint data;

    #400_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int     lat;
    longint data;
    logic [7:0] ba;
    logic [7:0] bb;
    int     l;
    int     waitCnt;

    bus.start       = 1'b0;
    bus.base_addr_a = '0;
    bus.base_addr_b = '0;
    bus.len         = '0;
    bus.res_ready   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end

    vecs[0] = '{8'h00, 8'h00, 4, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 70, 10};
    vecs[1] = '{8'h00, 8'h00, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 1};
    vecs[2] = '{8'h00, 8'h00, 3, '{-8192, -8192, -8192, 0}, '{-8192, -8192, -8192, 0}, 134217727, 9};
    vecs[3] = '{8'h00, 8'h00, 1, '{-3, 0, 0, 0}, '{7, 0, 0, 0}, -21, 7};
    vecs[4] = '{8'hFE, 8'h10, 4, '{1, -2, 3, -4}, '{100, 200, 300, 400}, -1000, 10};
    vecs[5] = '{8'h20, 8'h30, 2, '{8191, -8192, 0, 0}, '{8191, 8191, 0, 0}, -8191, 8};
    vecs[6] = '{8'h40, 8'h40, 3, '{-8192, -8192, -8192, 0}, '{8191, 8191, 8191, 0}, -134217728, 9};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", longint'(bus.busy), 0);
    checkOutput("reset_res_valid", longint'(bus.res_valid), 0);
    checkOutput("reset_mem_rd_en", longint'(bus.mem_rd_en), 0);
    checkOutput("reset_mac_valid_in", longint'(bus.mac_valid_in), 0);
    checkOutput("reset_mac_reset", longint'(bus.mac_reset), 1);
    checkOutput("reset_res_data", longint'(bus.res_data), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_mac_reset", longint'(bus.mac_reset), 0);

    // Table-driven jobs.
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < vecs[k].len; i++) begin
        memA[8'(vecs[k].baseA + 8'(i))] = 14'(vecs[k].a[i]);
        memB[8'(vecs[k].baseB + 8'(i))] = 14'(vecs[k].b[i]);
      end
      applyStimulus(vecs[k].baseA, vecs[k].baseB, vecs[k].len, lat);
      acceptResult($sformatf("vec%0d", k), k % 3, data);
      checkJob($sformatf("vec%0d", k), vecs[k].baseA, vecs[k].baseB, vecs[k].len,
               vecs[k].expData, vecs[k].expLat, data, lat);
    end

    // Back-to-back: start pulses while the result is held are ignored.
    for (int i = 0; i < 4; i++) begin
      memA[i] = 14'(i + 1);
      memB[i] = 14'(i + 5);
    end
    memA[8'h50] = -14'sd3;
    memB[8'h50] = 14'sd7;
    applyStimulus(8'h00, 8'h00, 4, lat);
    checkOutput("b2b_job1_latency", lat, 10);
    bus.base_addr_a = 8'h50;
    bus.base_addr_b = 8'h50;
    bus.len         = 9'd1;
    for (int h = 0; h < 5; h++) begin
      bus.start = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("b2b_hold%0d_res_valid", h), longint'(bus.res_valid), 1);
      checkOutput($sformatf("b2b_hold%0d_res_data", h), longint'(bus.res_data), 70);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput("b2b_start_on_accept_ignored", longint'(bus.busy), 0);
    @(negedge clk);
    checkOutput("b2b_still_idle", longint'(bus.busy), 0);
    applyStimulus(8'h50, 8'h50, 1, lat);
    acceptResult("b2b_job2", 0, data);
    checkJob("b2b_job2", 8'h50, 8'h50, 1, -21, 7, data, lat);

    // Asynchronous reset in the middle of ISSUE.
    @(negedge clk);
    bus.start       = 1'b1;
    bus.base_addr_a = 8'h00;
    bus.base_addr_b = 8'h00;
    bus.len         = 9'd4;
    @(negedge clk);
    bus.start = 1'b0;
    waitCnt = 0;
    while (!bus.mem_rd_en && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rst_reached_issue", longint'(bus.mem_rd_en), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_busy", longint'(bus.busy), 0);
    checkOutput("rst_async_mem_rd_en", longint'(bus.mem_rd_en), 0);
    checkOutput("rst_async_res_valid", longint'(bus.res_valid), 0);
    checkOutput("rst_async_mac_reset", longint'(bus.mac_reset), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'h00, 8'h00, 4, lat);
    acceptResult("post_rst_job", 1, data);
    checkJob("post_rst_job", 8'h00, 8'h00, 4, 70, 10, data, lat);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 256; i++) begin
        memA[i] = 14'($urandom);
        memB[i] = 14'($urandom);
      end
      ba = 8'($urandom);
      bb = 8'($urandom);
      l  = (j % 5 == 0) ? 0 : int'($urandom_range(1, 20));
      applyStimulus(ba, bb, l, lat);
      acceptResult($sformatf("rnd%0d", j), int'($urandom_range(0, 3)), data);
      checkJob($sformatf("rnd%0d", j), ba, bb, l, refDot(ba, bb, l),
               (l == 0) ? 1 : l + 6, data, lat);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
